// File: rtl/axi_wr_arbiter.sv
// Two-to-one AXI4 write-channel arbiter: round-robin whole-burst grants with AW/W kept
// together, in-order B routing back to the issuing requester, sticky per-requester errors.
module axi_wr_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ID_WIDTH        = 4
) (
  input  logic                clk_sys,
  input  logic                rst_sys,
  input  logic [31:0]         s0_axi_awaddr,
  input  logic [7:0]          s0_axi_awlen,
  input  logic                s0_axi_awvalid,
  output logic                s0_axi_awready,
  input  logic [31:0]         s0_axi_wdata,
  input  logic [3:0]          s0_axi_wstrb,
  input  logic                s0_axi_wlast,
  input  logic                s0_axi_wvalid,
  output logic                s0_axi_wready,
  output logic [1:0]          s0_axi_bresp,
  output logic                s0_axi_bvalid,
  input  logic                s0_axi_bready,
  input  logic [31:0]         s1_axi_awaddr,
  input  logic [7:0]          s1_axi_awlen,
  input  logic                s1_axi_awvalid,
  output logic                s1_axi_awready,
  input  logic [31:0]         s1_axi_wdata,
  input  logic [3:0]          s1_axi_wstrb,
  input  logic                s1_axi_wlast,
  input  logic                s1_axi_wvalid,
  output logic                s1_axi_wready,
  output logic [1:0]          s1_axi_bresp,
  output logic                s1_axi_bvalid,
  input  logic                s1_axi_bready,
  output logic [31:0]         mst_axi_awaddr,
  output logic [7:0]          mst_axi_awlen,
  output logic [ID_WIDTH-1:0] mst_axi_awid,
  output logic                mst_axi_awvalid,
  input  logic                mst_axi_awready,
  output logic [31:0]         mst_axi_wdata,
  output logic [3:0]          mst_axi_wstrb,
  output logic                mst_axi_wlast,
  output logic                mst_axi_wvalid,
  input  logic                mst_axi_wready,
  input  logic [1:0]          mst_axi_bresp,
  input  logic                mst_axi_bvalid,
  output logic                mst_axi_bready,
  output logic [1:0]          err_flags,
  input  logic                err_clr,
  output logic [4:0]          outstanding
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = 5;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                     state_q, state_d;
  logic                       grant_q, grant_d;
  logic                       last_grant_q, last_grant_d;
  logic [MAX_OUTSTANDING-1:0] order_q;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [1:0]                 err_q, err_d;

  logic        sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
  logic [31:0] sel_awaddr, sel_wdata;
  logic [7:0]  sel_awlen;
  logic [3:0]  sel_wstrb;
  logic        head, fifo_empty, push, pop, slot_free, b_route;

  // Views of the currently granted requester
  assign sel_awvalid = grant_q ? s1_axi_awvalid : s0_axi_awvalid;
  assign sel_awaddr  = grant_q ? s1_axi_awaddr  : s0_axi_awaddr;
  assign sel_awlen   = grant_q ? s1_axi_awlen   : s0_axi_awlen;
  assign sel_wvalid  = grant_q ? s1_axi_wvalid  : s0_axi_wvalid;
  assign sel_wdata   = grant_q ? s1_axi_wdata   : s0_axi_wdata;
  assign sel_wstrb   = grant_q ? s1_axi_wstrb   : s0_axi_wstrb;
  assign sel_wlast   = grant_q ? s1_axi_wlast   : s0_axi_wlast;

  // B path follows the oldest outstanding burst recorded in the order FIFO
  assign fifo_empty     = (count_q == '0);
  assign head           = order_q[rd_ptr_q];
  assign sel_bready     = head ? s1_axi_bready : s0_axi_bready;
  assign b_route        = !rst_sys && !fifo_empty;
  assign mst_axi_bready = b_route && sel_bready;
  assign s0_axi_bvalid  = b_route && !head && mst_axi_bvalid;
  assign s1_axi_bvalid  = b_route && head && mst_axi_bvalid;
  assign s0_axi_bresp   = (b_route && !head) ? mst_axi_bresp : 2'b00;
  assign s1_axi_bresp   = (b_route && head) ? mst_axi_bresp : 2'b00;

  assign pop       = mst_axi_bvalid && mst_axi_bready;
  assign push      = !rst_sys && (state_q == ADDR) && sel_awvalid && mst_axi_awready;
  assign slot_free = (count_q < CNT_MAX) || pop;

  assign err_flags   = err_q;
  assign outstanding = count_q;

  // Arbitration FSM and AW/W muxing; everything held at zero during reset
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    mst_axi_awaddr  = '0;
    mst_axi_awlen   = '0;
    mst_axi_awid    = '0;
    mst_axi_awvalid = 1'b0;
    mst_axi_wdata   = '0;
    mst_axi_wstrb   = '0;
    mst_axi_wlast   = 1'b0;
    mst_axi_wvalid  = 1'b0;
    s0_axi_awready  = 1'b0;
    s1_axi_awready  = 1'b0;
    s0_axi_wready   = 1'b0;
    s1_axi_wready   = 1'b0;
    if (!rst_sys) begin
      case (state_q)
        IDLE: begin
          if ((s0_axi_awvalid || s1_axi_awvalid) && slot_free) begin
            if (s0_axi_awvalid && s1_axi_awvalid) grant_d = ~last_grant_q;
            else                                  grant_d = s1_axi_awvalid;
            last_grant_d = grant_d;
            state_d      = ADDR;
          end
        end
        ADDR: begin
          mst_axi_awvalid = sel_awvalid;
          mst_axi_awaddr  = sel_awaddr;
          mst_axi_awlen   = sel_awlen;
          mst_axi_awid    = ID_WIDTH'(grant_q);
          s0_axi_awready  = !grant_q && mst_axi_awready;
          s1_axi_awready  = grant_q && mst_axi_awready;
          if (sel_awvalid && mst_axi_awready) state_d = DATA;
        end
        DATA: begin
          mst_axi_wvalid = sel_wvalid;
          mst_axi_wdata  = sel_wdata;
          mst_axi_wstrb  = sel_wstrb;
          mst_axi_wlast  = sel_wlast;
          s0_axi_wready  = !grant_q && mst_axi_wready;
          s1_axi_wready  = grant_q && mst_axi_wready;
          if (sel_wvalid && mst_axi_wready && sel_wlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Order FIFO pointers, occupancy and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_clr ? 2'b00 : err_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
    if (pop && (mst_axi_bresp != 2'b00)) err_d[head] = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  // Entry storage needs no reset: occupancy qualifies every read
  always_ff @(posedge clk_sys) begin
    if (push) order_q[wr_ptr_q] <= grant_q;
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: AW/W/B expectations are queued from the requester
// side and checked where the arbiter emits them; scenario tasks add timing checks.
module tb_axi_wr_arbiter;

  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [3:0] id;} aw_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} w_t;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic [31:0] s_awaddr [2];
  logic [7:0]  s_awlen  [2];
  logic [31:0] s_wdata  [2];
  logic [3:0]  s_wstrb  [2];
  logic [1:0]  s_awvalid, s_wvalid, s_wlast, s_bready;
  logic        s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid;
  logic [1:0]  s0_bresp, s1_bresp;
  logic [1:0]  s_awready, s_wready, s_bvalid;
  logic [1:0]  s_bresp_v [2];
  logic [31:0] m_awaddr, m_wdata;
  logic [7:0]  m_awlen;
  logic [3:0]  m_awid, m_wstrb;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  m_bresp, err_flags;
  logic        err_clr;
  logic [4:0]  outstanding;

  assign s_awready    = {s1_awready, s0_awready};
  assign s_wready     = {s1_wready, s0_wready};
  assign s_bvalid     = {s1_bvalid, s0_bvalid};
  assign s_bresp_v[0] = s0_bresp;
  assign s_bresp_v[1] = s1_bresp;

  int  n_cmp = 0, n_bad = 0, cyc = 0, w_beats = 0, cur_w_port = 0;
  bit  in_burst = 0;
  logic prev_awvalid = 1'b0;
  aw_t aw_exp[$];
  w_t  w_exp[$];
  int  b_exp[$], b_log[$], grant_log[$], aw_rise[$], wlast_cyc[$];

  always #5 clk_sys = ~clk_sys;

  axi_wr_arbiter #(.MAX_OUTSTANDING(4), .ID_WIDTH(4)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awlen(s_awlen[0]), .s0_axi_awvalid(s_awvalid[0]),
    .s0_axi_awready(s0_awready), .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]),
    .s0_axi_wlast(s_wlast[0]), .s0_axi_wvalid(s_wvalid[0]), .s0_axi_wready(s0_wready),
    .s0_axi_bresp(s0_bresp), .s0_axi_bvalid(s0_bvalid), .s0_axi_bready(s_bready[0]),
    .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awlen(s_awlen[1]), .s1_axi_awvalid(s_awvalid[1]),
    .s1_axi_awready(s1_awready), .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]),
    .s1_axi_wlast(s_wlast[1]), .s1_axi_wvalid(s_wvalid[1]), .s1_axi_wready(s1_wready),
    .s1_axi_bresp(s1_bresp), .s1_axi_bvalid(s1_bvalid), .s1_axi_bready(s_bready[1]),
    .mst_axi_awaddr(m_awaddr), .mst_axi_awlen(m_awlen), .mst_axi_awid(m_awid),
    .mst_axi_awvalid(m_awvalid), .mst_axi_awready(m_awready),
    .mst_axi_wdata(m_wdata), .mst_axi_wstrb(m_wstrb), .mst_axi_wlast(m_wlast),
    .mst_axi_wvalid(m_wvalid), .mst_axi_wready(m_wready),
    .mst_axi_bresp(m_bresp), .mst_axi_bvalid(m_bvalid), .mst_axi_bready(m_bready),
    .err_flags(err_flags), .err_clr(err_clr), .outstanding(outstanding)
  );

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk_sys) begin : mon
    aw_t ea;
    w_t  ew;
    int  eb;
    cyc++;
    if (rst_sys) begin
      aw_exp.delete(); w_exp.delete(); b_exp.delete(); b_log.delete();
      grant_log.delete(); aw_rise.delete(); wlast_cyc.delete();
      in_burst = 0; w_beats = 0; prev_awvalid = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (s_awvalid[p] && s_awready[p]) begin
          n_cmp++;
          if (in_burst) begin
            n_bad++; $display("FAIL aw_overlap port=%0d got AW before previous wlast", p);
          end
          aw_exp.push_back('{addr: s_awaddr[p], len: s_awlen[p], id: 4'(p)});
          b_exp.push_back(p);
          cur_w_port = p;
          in_burst = 1;
        end
        if (s_wvalid[p] && s_wready[p]) begin
          n_cmp++;
          if (!in_burst || p != cur_w_port) begin
            n_bad++; $display("FAIL w_port got=%0d want=%0d in_burst=%0d", p, cur_w_port, in_burst);
          end
          w_exp.push_back('{data: s_wdata[p], strb: s_wstrb[p], last: s_wlast[p]});
          if (s_wlast[p]) in_burst = 0;
        end
      end
      if (m_awvalid && m_awready) begin
        grant_log.push_back(int'(m_awid));
        n_cmp++;
        if (aw_exp.size() == 0) begin
          n_bad++; $display("FAIL aw_unexpected got addr=%h", m_awaddr);
        end else begin
          ea = aw_exp.pop_front();
          if ({m_awaddr, m_awlen, m_awid} !== ea) begin
            n_bad++; $display("FAIL aw_payload got=%h/%0d/%0d want=%h/%0d/%0d",
                              m_awaddr, m_awlen, m_awid, ea.addr, ea.len, ea.id);
          end
        end
      end
      if (m_wvalid && m_wready) begin
        w_beats++;
        n_cmp++;
        if (w_exp.size() == 0) begin
          n_bad++; $display("FAIL w_unexpected got data=%h", m_wdata);
        end else begin
          ew = w_exp.pop_front();
          if ({m_wdata, m_wstrb, m_wlast} !== ew) begin
            n_bad++; $display("FAIL w_payload got=%h/%h/%0d want=%h/%h/%0d",
                              m_wdata, m_wstrb, m_wlast, ew.data, ew.strb, ew.last);
          end
        end
        if (m_wlast) wlast_cyc.push_back(cyc);
      end
      if (m_awvalid && !prev_awvalid) aw_rise.push_back(cyc);
      prev_awvalid = m_awvalid;
      if (s_bvalid == 2'b11) begin
        n_cmp++; n_bad++; $display("FAIL b_both got bvalid=%b want one-hot", s_bvalid);
      end
      for (int p = 0; p < 2; p++) begin
        if (s_bvalid[p] && s_bready[p]) begin
          b_log.push_back(p);
          n_cmp++;
          eb = (b_exp.size() == 0) ? -1 : b_exp.pop_front();
          if (eb != p || s_bresp_v[p] !== m_bresp) begin
            n_bad++; $display("FAIL b_route got port=%0d resp=%0d want port=%0d resp=%0d",
                              p, s_bresp_v[p], eb, m_bresp);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_sys = 1'b1;
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = 2'b11;
    for (int p = 0; p < 2; p++) begin
      s_awaddr[p] = '0; s_awlen[p] = '0; s_wdata[p] = '0; s_wstrb[p] = '0;
    end
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00; err_clr = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 rst_sys = 1'b0;
  endtask

  task automatic send_burst(input int p, input logic [31:0] addr, input logic [7:0] len);
    int n;
    bit hs;
    s_awaddr[p] = addr; s_awlen[p] = len; s_awvalid[p] = 1'b1;
    n = 0; hs = 0;
    while (!hs && n < 2000) begin
      @(negedge clk_sys); hs = s_awready[p]; n++;
      @(posedge clk_sys); #1;
    end
    s_awvalid[p] = 1'b0;
    n_cmp++;
    if (!hs) begin
      n_bad++; $display("FAIL aw_timeout port=%0d got no awready want handshake", p); return;
    end
    for (int i = 0; i <= int'(len); i++) begin
      s_wdata[p] = $urandom; s_wstrb[p] = 4'($urandom);
      s_wlast[p] = (i == int'(len)); s_wvalid[p] = 1'b1;
      n = 0; hs = 0;
      while (!hs && n < 200) begin
        @(negedge clk_sys); hs = s_wready[p]; n++;
        @(posedge clk_sys); #1;
      end
      if (!hs) begin
        n_cmp++; n_bad++; $display("FAIL w_timeout port=%0d beat=%0d got no wready", p, i);
        s_wvalid[p] = 1'b0; s_wlast[p] = 1'b0; return;
      end
    end
    s_wvalid[p] = 1'b0; s_wlast[p] = 1'b0;
  endtask

  task automatic return_b(input logic [1:0] resp);
    int n = 0;
    bit hs = 0;
    m_bvalid = 1'b1; m_bresp = resp;
    while (!hs && n < 200) begin
      @(negedge clk_sys); hs = m_bready; n++;
      @(posedge clk_sys); #1;
    end
    m_bvalid = 1'b0; m_bresp = 2'b00;
    n_cmp++;
    if (!hs) begin n_bad++; $display("FAIL b_timeout got no bready want handshake"); end
  endtask

  task automatic test_reset();
    rst_sys = 1'b1;
    s_awvalid = 2'b11; s_wvalid = 2'b11;
    @(negedge clk_sys);
    n_cmp++;
    if ({m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid} !== 9'd0 ||
        m_awaddr !== 32'd0 || m_wdata !== 32'd0) begin
      n_bad++; $display("FAIL reset_outputs got aw=%b w=%b b=%b want all zero", m_awvalid, m_wvalid, m_bready);
    end
    n_cmp++;
    if (outstanding !== 5'd0 || err_flags !== 2'b00) begin
      n_bad++; $display("FAIL reset_state got out=%0d err=%b want 0/00", outstanding, err_flags);
    end
    @(posedge clk_sys); #1;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    fork
      send_burst(0, 32'h0000_1000, 8'd127);
      begin
        @(negedge clk_sys);
        n_cmp++;
        if (m_awvalid !== 1'b0) begin n_bad++; $display("FAIL arb_latency_t got=%b want 0", m_awvalid); end
        @(negedge clk_sys);
        n_cmp++;
        if (m_awvalid !== 1'b1 || m_awid !== 4'd0) begin
          n_bad++; $display("FAIL arb_latency_t1 got awvalid=%b id=%0d want 1/0", m_awvalid, m_awid);
        end
      end
    join
    n_cmp++;
    if (w_beats != 128) begin n_bad++; $display("FAIL single_beats got=%0d want 128", w_beats); end
    n_cmp++;
    if (outstanding !== 5'd1) begin n_bad++; $display("FAIL single_out1 got=%0d want 1", outstanding); end
    return_b(2'b00);
    n_cmp++;
    if (outstanding !== 5'd0 || b_log.size() != 1) begin
      n_bad++; $display("FAIL single_out0 got out=%0d nb=%0d want 0/1", outstanding, b_log.size());
    end
  endtask

  task automatic test_contention();
    int want[4] = '{0, 1, 0, 1};
    do_reset();
    fork
      begin send_burst(0, 32'h0000_2000, 8'd3); send_burst(0, 32'h0000_2100, 8'd3); end
      begin send_burst(1, 32'h0000_3000, 8'd3); send_burst(1, 32'h0000_3100, 8'd3); end
    join
    n_cmp++;
    if (grant_log.size() != 4 || aw_rise.size() != 4 || wlast_cyc.size() != 4) begin
      n_bad++; $display("FAIL rr_count got grants=%0d rises=%0d want 4/4", grant_log.size(), aw_rise.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (grant_log[i] != want[i]) begin
          n_bad++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, grant_log[i], want[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (aw_rise[i+1] - wlast_cyc[i] != 2) begin
          n_bad++; $display("FAIL rr_gap idx=%0d got=%0d want 2", i, aw_rise[i+1] - wlast_cyc[i]);
        end
      end
    end
    repeat (4) return_b(2'b00);
    n_cmp++;
    if (outstanding !== 5'd0) begin n_bad++; $display("FAIL rr_drain got=%0d want 0", outstanding); end
  endtask

  task automatic test_outstanding();
    do_reset();
    for (int i = 0; i < 4; i++) send_burst(0, 32'h0001_0000 + 32'(i * 64), 8'd1);
    n_cmp++;
    if (outstanding !== 5'd4) begin n_bad++; $display("FAIL full_count got=%0d want 4", outstanding); end
    fork
      send_burst(1, 32'h0000_5000, 8'd0);
      begin
        repeat (4) begin
          @(negedge clk_sys);
          n_cmp++;
          if (m_awvalid !== 1'b0) begin n_bad++; $display("FAIL full_stall got awvalid=%b want 0", m_awvalid); end
        end
        @(posedge clk_sys); #1;
        m_bvalid = 1'b1;
        @(negedge clk_sys);
        n_cmp++;
        if (m_bready !== 1'b1 || m_awvalid !== 1'b0) begin
          n_bad++; $display("FAIL full_pop got bready=%b awvalid=%b want 1/0", m_bready, m_awvalid);
        end
        @(posedge clk_sys); #1;
        m_bvalid = 1'b0;
        @(negedge clk_sys);
        n_cmp++;
        if (m_awvalid !== 1'b1 || m_awid !== 4'd1) begin
          n_bad++; $display("FAIL full_regrant got awvalid=%b id=%0d want 1/1", m_awvalid, m_awid);
        end
        @(posedge clk_sys); #1;
      end
    join
    repeat (4) return_b(2'b00);
    n_cmp++;
    if (b_log.size() != 5 || outstanding !== 5'd0) begin
      n_bad++; $display("FAIL full_drain got nb=%0d out=%0d want 5/0", b_log.size(), outstanding);
    end else begin
      n_cmp++;
      if (b_log[4] != 1) begin n_bad++; $display("FAIL full_last_b got=%0d want 1", b_log[4]); end
    end
  endtask

  task automatic test_b_order();
    int want[3] = '{1, 0, 1};
    int n = 0, k = 0;
    do_reset();
    send_burst(1, 32'h0000_6000, 8'd0);
    send_burst(0, 32'h0000_7000, 8'd0);
    send_burst(1, 32'h0000_8000, 8'd2);
    s_bready[1] = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b00;
    repeat (5) begin
      @(negedge clk_sys);
      n_cmp++;
      if (m_bready !== 1'b0 || s_bvalid !== 2'b10) begin
        n_bad++; $display("FAIL b_backpressure got bready=%b bvalid=%b want 0/10", m_bready, s_bvalid);
      end
      @(posedge clk_sys); #1;
    end
    s_bready[1] = 1'b1;
    while (k < 3 && n < 50) begin
      @(negedge clk_sys);
      if (m_bvalid && m_bready) k++;
      n++;
      @(posedge clk_sys); #1;
      if (k == 3) m_bvalid = 1'b0;
    end
    m_bvalid = 1'b0;
    n_cmp++;
    if (b_log.size() != 3) begin
      n_bad++; $display("FAIL b_order_count got=%0d want 3", b_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (b_log[i] != want[i]) begin
          n_bad++; $display("FAIL b_order idx=%0d got=%0d want=%0d", i, b_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_errors();
    do_reset();
    send_burst(0, 32'h0000_9000, 8'd0);
    return_b(2'b10);
    n_cmp++;
    if (err_flags !== 2'b01) begin n_bad++; $display("FAIL err_s0 got=%b want 01", err_flags); end
    send_burst(1, 32'h0000_A000, 8'd0);
    m_bvalid = 1'b1; m_bresp = 2'b10; err_clr = 1'b1;
    @(negedge clk_sys);
    n_cmp++;
    if (m_bready !== 1'b1) begin n_bad++; $display("FAIL err_s1_hs got bready=%b want 1", m_bready); end
    @(posedge clk_sys); #1;
    m_bvalid = 1'b0; m_bresp = 2'b00; err_clr = 1'b0;
    @(negedge clk_sys);
    n_cmp++;
    if (err_flags !== 2'b10) begin n_bad++; $display("FAIL err_clr_race got=%b want 10", err_flags); end
    @(posedge clk_sys); #1;
    err_clr = 1'b1;
    @(posedge clk_sys); #1;
    err_clr = 1'b0;
    @(negedge clk_sys);
    n_cmp++;
    if (err_flags !== 2'b00) begin n_bad++; $display("FAIL err_clear got=%b want 00", err_flags); end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_reset_mid();
    int n = 0, k = 0;
    bit hs = 0;
    do_reset();
    s_awaddr[0] = 32'h0000_B000; s_awlen[0] = 8'd63; s_awvalid[0] = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk_sys); hs = s_awready[0]; n++;
      @(posedge clk_sys); #1;
    end
    s_awvalid[0] = 1'b0;
    n = 0;
    while (k < 10 && n < 100) begin
      s_wdata[0] = $urandom; s_wstrb[0] = 4'hF; s_wvalid[0] = 1'b1;
      @(negedge clk_sys);
      if (s_wready[0]) k++;
      n++;
      @(posedge clk_sys); #1;
    end
    n_cmp++;
    if (k != 10) begin n_bad++; $display("FAIL mid_beats got=%0d want 10", k); end
    rst_sys = 1'b1;
    s_wdata[0] = 32'hDEAD_BEEF; s_awvalid[1] = 1'b1;
    @(negedge clk_sys);
    n_cmp++;
    if ({m_awvalid, m_wvalid, m_bready, s_awready, s_wready} !== 7'd0 || m_wdata !== 32'd0) begin
      n_bad++; $display("FAIL mid_reset_out got wvalid=%b wdata=%h wready=%b want 0", m_wvalid, m_wdata, s_wready);
    end
    @(posedge clk_sys); #1;
    s_wvalid = '0; s_awvalid = '0;
    @(negedge clk_sys);
    n_cmp++;
    if (outstanding !== 5'd0 || m_wvalid !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_state got out=%0d wvalid=%b want 0/0", outstanding, m_wvalid);
    end
    @(posedge clk_sys); #1;
    rst_sys = 1'b0;
    fork
      send_burst(0, 32'h0000_C000, 8'd0);
      send_burst(1, 32'h0000_D000, 8'd0);
    join
    n_cmp++;
    if (grant_log.size() != 2 || grant_log[0] != 0) begin
      n_bad++; $display("FAIL mid_regrant got n=%0d first=%0d want 2/0", grant_log.size(),
                        grant_log.size() > 0 ? grant_log[0] : -1);
    end
    repeat (2) return_b(2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_contention();
    test_outstanding();
    test_b_order();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
